// File: rtl/apb_ext_window_bridge_pkg.sv
// Shared types and helpers for the APB external-window bridge.
// Holds the FSM encoding, strobe-to-bit-mask expansion and channel-field sizing.
package apb_ext_window_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Widest strobe vector the helper handles (256-bit data)
    localparam int MAX_STRB = 32;

    function automatic logic [MAX_STRB*8-1:0] strb_to_biten(input logic [MAX_STRB-1:0] strb);
        logic [MAX_STRB*8-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_STRB; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

    // A single window still needs a 1-bit field so "ch >= NUM_CH" catches the next window up
    function automatic int ch_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_ext_ack_timer.sv
// Saturating ack watchdog: counts enabled cycles, expired flags the LIMIT-th one.
// Single-cycle clear/enable, no backpressure; present only with APB_EXT_TIMEOUT_EN.
module apb_ext_ack_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // High during the LIMIT-th enabled cycle so the caller can leave on that edge
    assign expired = en && (cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/apb_ext_window_bridge.sv
// APB slave mapping NUM_CH windows onto external reg-block ports; 3-cycle minimum access, pready held off until the matching ack.
// Optional ack watchdog when APB_EXT_TIMEOUT_EN is defined; unmapped addresses answer at once with pslverr.
module apb_ext_window_bridge #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int NUM_CH  = 4,
    parameter int WIN_AW  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_apb_psel,
    input  logic                           s_apb_penable,
    input  logic                           s_apb_pwrite,
    input  logic [2:0]                     s_apb_pprot,
    input  logic [ADDR_W-1:0]              s_apb_paddr,
    input  logic [DATA_W-1:0]              s_apb_pwdata,
    input  logic [DATA_W/8-1:0]            s_apb_pstrb,
    output logic                           s_apb_pready,
    output logic [DATA_W-1:0]              s_apb_prdata,
    output logic                           s_apb_pslverr,
    output logic [NUM_CH-1:0]              hwif_out_ext_req,
    output logic                           hwif_out_ext_req_is_wr,
    output logic [WIN_AW-1:0]              hwif_out_ext_addr,
    output logic [DATA_W-1:0]              hwif_out_ext_wr_data,
    output logic [DATA_W-1:0]              hwif_out_ext_wr_biten,
    input  logic [NUM_CH-1:0]              hwif_in_ext_rd_ack,
    input  logic [NUM_CH-1:0]              hwif_in_ext_wr_ack,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  hwif_in_ext_rd_data
);

    import apb_ext_window_bridge_pkg::*;

    localparam int CH_W = ch_bits(NUM_CH);

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q;
    logic               err_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [CH_W-1:0]    dec_ch;
    logic               upper_nz;
    logic               dec_unmapped;
    logic               access;
    logic               ack_hit;
    logic               tmo;
    logic               unused_pprot;

    assign unused_pprot = ^s_apb_pprot;

    assign dec_ch = s_apb_paddr[WIN_AW +: CH_W];

    generate
        if (ADDR_W > WIN_AW + CH_W) begin : g_upper
            assign upper_nz = |s_apb_paddr[ADDR_W-1:WIN_AW+CH_W];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    // Widened compare keeps the range check meaningful when NUM_CH is a power of two
    assign dec_unmapped = upper_nz || ({1'b0, dec_ch} >= (CH_W+1)'(NUM_CH));
    assign access       = s_apb_psel && s_apb_penable;
    assign ack_hit      = hwif_out_ext_req_is_wr ? hwif_in_ext_wr_ack[ch_q]
                                                 : hwif_in_ext_rd_ack[ch_q];

`ifdef APB_EXT_TIMEOUT_EN
    apb_ext_ack_timer #(
        .LIMIT (TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != ST_WAIT),
        .en      (state_q == ST_WAIT),
        .expired (tmo)
    );
`else
    localparam int unused_timeout = TIMEOUT;
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (access) state_d = dec_unmapped ? ST_RESP : ST_REQ;
            ST_REQ:  state_d = ack_hit ? ST_RESP : ST_WAIT;
            ST_WAIT: if (ack_hit || tmo) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q                <= ST_IDLE;
            ch_q                   <= '0;
            err_q                  <= 1'b0;
            rdata_q                <= '0;
            hwif_out_ext_req_is_wr <= 1'b0;
            hwif_out_ext_addr      <= '0;
            hwif_out_ext_wr_data   <= '0;
            hwif_out_ext_wr_biten  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        ch_q                   <= dec_ch;
                        err_q                  <= dec_unmapped;
                        rdata_q                <= '0;
                        hwif_out_ext_req_is_wr <= s_apb_pwrite;
                        hwif_out_ext_addr      <= s_apb_paddr[WIN_AW-1:0];
                        hwif_out_ext_wr_data   <= s_apb_pwdata;
                        hwif_out_ext_wr_biten  <= DATA_W'(strb_to_biten(MAX_STRB'(s_apb_pstrb)));
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (ack_hit) begin
                        if (!hwif_out_ext_req_is_wr) rdata_q <= hwif_in_ext_rd_data[ch_q];
                    end else if (tmo) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_apb_pready     = (state_q == ST_RESP);
    assign s_apb_pslverr    = s_apb_pready && err_q;
    assign s_apb_prdata     = s_apb_pready ? rdata_q : '0;
    assign hwif_out_ext_req = (state_q == ST_REQ) ? (NUM_CH'(1) << ch_q) : '0;

endmodule

// File: tb/tb_apb_ext_window_bridge.sv
// Bench for apb_ext_window_bridge: randomized APB traffic against a window/memory model, scoreboarded responses.
module tb_apb_ext_window_bridge;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int WIN_AW = 10;
`ifdef APB_EXT_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 255;
`endif

    logic                          clk;
    logic                          rst;
    logic                          psel, penable, pwrite;
    logic [2:0]                    pprot;
    logic [ADDR_W-1:0]             paddr;
    logic [DATA_W-1:0]             pwdata;
    logic [3:0]                    pstrb;
    logic                          pready, pslverr;
    logic [DATA_W-1:0]             prdata;
    logic [NUM_CH-1:0]             req;
    logic                          req_is_wr;
    logic [WIN_AW-1:0]             ext_addr;
    logic [DATA_W-1:0]             ext_wdata, ext_biten;
    logic [NUM_CH-1:0]             rd_ack, wr_ack;
    logic [NUM_CH-1:0][DATA_W-1:0] rd_data;

    apb_ext_window_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .WIN_AW(WIN_AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_pprot(pprot),
        .s_apb_paddr(paddr), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
        .s_apb_pready(pready), .s_apb_prdata(prdata), .s_apb_pslverr(pslverr),
        .hwif_out_ext_req(req), .hwif_out_ext_req_is_wr(req_is_wr), .hwif_out_ext_addr(ext_addr),
        .hwif_out_ext_wr_data(ext_wdata), .hwif_out_ext_wr_biten(ext_biten),
        .hwif_in_ext_rd_ack(rd_ack), .hwif_in_ext_wr_ack(wr_ack), .hwif_in_ext_rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    typedef struct {
        int          ch;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] biten;
    } req_t;

    resp_t       resp_q[$];
    req_t        req_q[$];
    logic [31:0] ref_mem [NUM_CH][256];
    logic [31:0] dev_mem [NUM_CH][256];

    int checks = 0;
    int errors = 0;
    int next_delay = 0;
    int pready_events = 0;
    bit force_stray = 0;
    bit force_late = 0;
    bit drop_pending = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pready"},  64'(pready), 64'd0);
        chk({tag, "_pslverr"}, 64'(pslverr), 64'd0);
        chk({tag, "_prdata"},  64'(prdata), 64'd0);
        chk({tag, "_req"},     64'(req), 64'd0);
        chk({tag, "_is_wr"},   64'(req_is_wr), 64'd0);
        chk({tag, "_addr"},    64'(ext_addr), 64'd0);
        chk({tag, "_wdata"},   64'(ext_wdata), 64'd0);
        chk({tag, "_biten"},   64'(ext_biten), 64'd0);
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] st);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (st[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // Reference: window n covers byte addresses [n*1024, (n+1)*1024); anything beyond NUM_CH windows errors
    task automatic predict(input logic [14:0] a, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, input int dly);
        int    ch, off, word;
        bit    mapped;
        req_t  r;
        resp_t p;
        mapped = int'(a) < NUM_CH * (1 << WIN_AW);
        ch     = int'(a) / (1 << WIN_AW);
        off    = int'(a) % (1 << WIN_AW);
        word   = off / 4;
        if (mapped) begin
            r.ch = ch; r.wr = wr; r.addr = 10'(off); r.wdata = wd; r.biten = lane_mask(st);
            req_q.push_back(r);
        end
        if (!mapped) begin
            p.rdata = '0; p.err = 1'b1; p.lat = 2;
        end else if (dly < 0) begin
            p.rdata = '0; p.err = 1'b1; p.lat = 3 + TIMEOUT;
        end else begin
            p.err = 1'b0; p.lat = 3 + dly;
            p.rdata = wr ? 32'h0 : ref_mem[ch][word];
            if (wr) ref_mem[ch][word] = (ref_mem[ch][word] & ~lane_mask(st)) | (wd & lane_mask(st));
        end
        if (dly >= 0 || mapped) resp_q.push_back(p);
    endtask

    task automatic apb_xfer(input logic [14:0] a, input logic wr, input logic [31:0] wd,
                            input logic [3:0] st, input int dly);
        bit seen;
        predict(a, wr, wd, st, dly);
        next_delay = dly;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd; pstrb = st;
        pprot = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        penable = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (pready) seen = 1;
        end
        if (!seen) bound_fail("apb_pready_wait");
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Completion monitor: pops the expected response whenever the DUT presents pready
    initial begin : monitor
        resp_t p;
        int    acc_cnt;
        bit    prev_rdy;
        acc_cnt = 0;
        prev_rdy = 0;
        forever begin
            @(negedge clk);
            if (psel && penable) acc_cnt++;
            else acc_cnt = 0;
            if (prev_rdy) begin
                chk("prdata_after_resp", 64'(prdata), 64'd0);
                chk("pslverr_after_resp", 64'(pslverr), 64'd0);
            end
            prev_rdy = pready;
            if (pready) begin
                pready_events++;
                if (resp_q.size() == 0) begin
                    bound_fail("unexpected_pready");
                end else begin
                    p = resp_q.pop_front();
                    chk("prdata", 64'(prdata), 64'(p.rdata));
                    chk("pslverr", 64'(pslverr), 64'(p.err));
                    chk("access_cycles", 64'(acc_cnt), 64'(p.lat));
                end
                acc_cnt = 0;
            end
        end
    end

    // External register-block model: checks each req, acks after the scheduled delay, sprays stray acks
    initial begin : responder
        req_t                          r;
        logic [NUM_CH-1:0]             prev_req;
        logic [NUM_CH-1:0]             rd_a, wr_a;
        logic [31:0]                   rnd;
        bit                            pending;
        int                            p_ch, p_cnt;
        bit                            p_wr;
        prev_req = '0; pending = 0; p_ch = 0; p_cnt = 0; p_wr = 0;
        rd_ack = '0; wr_ack = '0; rd_data = '0;
        forever begin
            @(negedge clk);
            if (prev_req != '0) chk("req_one_cycle", 64'(req), 64'd0);
            prev_req = req;
            if (drop_pending) pending = 0;
            if (req != '0) begin
                if (req_q.size() == 0) begin
                    bound_fail("unexpected_req");
                end else begin
                    r = req_q.pop_front();
                    chk("req_onehot", 64'(req), 64'(1) << r.ch);
                    chk("req_is_wr", 64'(req_is_wr), 64'(r.wr));
                    chk("req_addr", 64'(ext_addr), 64'(r.addr));
                    chk("req_wdata", 64'(ext_wdata), 64'(r.wdata));
                    chk("req_biten", 64'(ext_biten), 64'(r.biten));
                    pending = 1; p_ch = r.ch; p_wr = r.wr; p_cnt = next_delay;
                end
            end
            rnd = $urandom; rd_a = rnd[3:0];
            rnd = $urandom; wr_a = rnd[3:0];
            for (int c = 0; c < NUM_CH; c++) rd_data[c] = $urandom;
            if (force_late) rd_a[2] = 1'b1;
            if (pending) begin
                if (p_wr) wr_a[p_ch] = 1'b0;
                else rd_a[p_ch] = 1'b0;
                if (force_stray) wr_a[2] = 1'b1;
                if (p_cnt == 0) begin
                    if (p_wr) begin
                        wr_a[p_ch] = 1'b1;
                        dev_mem[p_ch][int'(ext_addr[9:2])] =
                            (dev_mem[p_ch][int'(ext_addr[9:2])] & ~ext_biten) | (ext_wdata & ext_biten);
                    end else begin
                        rd_a[p_ch] = 1'b1;
                        rd_data[p_ch] = dev_mem[p_ch][int'(ext_addr[9:2])];
                    end
                    pending = 0;
                end else if (p_cnt > 0) begin
                    p_cnt--;
                end
            end
            rd_ack = rd_a;
            wr_ack = wr_a;
        end
    end

    initial begin : stimulus
        logic [31:0] rnd;
        logic [14:0] a;
        int          kind, evts;
        bit          drained;
        psel = 0; penable = 0; pwrite = 0; pprot = '0; paddr = '0; pwdata = '0; pstrb = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int w = 0; w < 256; w++) begin
                rnd = $urandom;
                ref_mem[c][w] = rnd;
                dev_mem[c][w] = rnd;
            end
        ref_mem[3][4] = 32'h12345678;
        dev_mem[3][4] = 32'h12345678;

        rst = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        apb_xfer(15'h0404, 1'b1, 32'hDEADBEEF, 4'hF, 2);
        apb_xfer(15'h0C10, 1'b0, 32'h0, 4'hF, 0);
        apb_xfer(15'h1000, 1'b1, 32'hCAFEF00D, 4'hF, 0);
        force_stray = 1;
        apb_xfer(15'h0008, 1'b1, 32'hA5A5_5A5A, 4'b0101, 3);
        force_stray = 0;
        apb_xfer(15'h0008, 1'b0, 32'h0, 4'h0, 1);
        apb_xfer(15'h0404, 1'b0, 32'h0, 4'hF, 0);

`ifdef APB_EXT_TIMEOUT_EN
        apb_xfer(15'h0800, 1'b0, 32'h0, 4'hF, -1);
        drop_pending = 1;
        evts = pready_events;
        @(posedge clk); #1;
        drop_pending = 0;
        force_late = 1;
        repeat (4) @(posedge clk);
        #1;
        force_late = 0;
        chk("late_ack_no_pready", 64'(pready_events - evts), 64'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 7);
            rnd = $urandom;
            if (kind == 0) a = rnd[14:0];
            else if (kind == 1) a = 15'h1000 + 15'(rnd[5:0] * 4);
            else a = 15'($urandom_range(0, NUM_CH - 1) * 1024 + $urandom_range(0, 15) * 4);
            rnd = $urandom;
            apb_xfer(a, rnd[0], $urandom, rnd[7:4], $urandom_range(0, 4));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Reset while the bridge waits for an ack that never comes
        begin
            req_t r;
            r.ch = 0; r.wr = 1'b0; r.addr = 10'h020; r.wdata = 32'h0BADF00D; r.biten = 32'hFFFFFFFF;
            req_q.push_back(r);
            next_delay = -1;
            @(posedge clk); #1;
            psel = 1'b1; penable = 1'b0; paddr = 15'h0020; pwrite = 1'b0;
            pwdata = 32'h0BADF00D; pstrb = 4'hF;
            @(posedge clk); #1;
            penable = 1'b1;
            repeat (3) @(negedge clk);
            #2;
            rst = 1'b0;
            #1;
            check_all_zero("rst_mid");
            psel = 1'b0; penable = 1'b0;
            drop_pending = 1;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            drop_pending = 0;
        end
        apb_xfer(15'h0020, 1'b0, 32'h0, 4'hF, 1);
        apb_xfer(15'h0024, 1'b1, 32'h13572468, 4'b1000, 0);
        apb_xfer(15'h0024, 1'b0, 32'h0, 4'hF, 2);

        drained = 0;
        for (int i = 0; i < 100 && !drained; i++) begin
            @(posedge clk);
            if (resp_q.size() == 0 && req_q.size() == 0) drained = 1;
        end
        if (!drained) bound_fail("scoreboard_drain");
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
